posit_unpack_stage: RTL and testbench
=====================================

# posit_unpack_stage

Pipelined stage directly downstream of the 8-bit posit field decoder. It accepts one decoded operand per cycle: sign, signed regime, exponent, fraction and the zero/NaR/all-ones flags. It classifies the operand and produces a unified signed scale `k*2^es + e` and a significand with the hidden bit, ready for the posit arithmetic datapath. It uses a valid/ready handshake, has two register stages, and keeps saturating event counters for zero and NaR operands.

## Interface
- `N`, 8: posit width; must match the decoder.
- `ES`, 1: exponent field width.
- `RS`, 4: regime field width; regime is two's-complement k.
- `FS`, N-ES-3: fraction field width.
- `SW`, RS+ES: scale width (signed).
- `CW`, 8: width of each event counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decoded operand present.
- `in_ready`  out  1  stage can accept the operand this cycle.
- `in_sign`  in  1  posit sign bit.
- `in_r`  in  RS  regime k, two's complement.
- `in_e`  in  ES  exponent bits, unsigned.
- `in_frac`  in  FS  fraction bits, MSB first.
- `in_z`  in  1  operand is zero.
- `in_inf`  in  1  operand is NaR.
- `in_allone`  in  1  magnitude is maxpos (informational; k already valid).
- `out_valid`  out  1  unpacked result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_sign`  out  1  sign; 0 for zero and NaR.
- `out_scale`  out  SW  signed k*2^ES + e.
- `out_sig`  out  FS+1  {1'b1, frac}; all zero for zero and NaR.
- `out_zero`  out  1  class: zero.
- `out_nar`  out  1  class: NaR.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `zero_cnt`  out  CW  saturating count of accepted zero operands.
- `nar_cnt`  out  CW  saturating count of accepted NaR operands.

## Operation
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1) registers the raw fields and resolves the class:
  - NaR if `in_inf`; else zero if `in_z`; else normal.
  - `in_inf` has priority over `in_z` if both are set.
- Stage 2 (S2) computes:
  - `scale = ({{ES{k[RS-1]}},k} <<< ES) + {0,e}`, in SW bits signed.
  - `sig = {1, frac}`.
  - For zero and NaR: `scale`, `sig` and `sign` are forced to 0, whatever the field values.
- Scale arithmetic: `in_r` is sign-extended to SW, shifted left by ES, and `in_e` is zero-extended and added. No overflow is possible at SW = RS+ES.
- Counters:
  - Each counter increments by 1 on an input transfer of its class and saturates at 2^CW-1.
  - `cnt_clr` zeroes both counters. If `cnt_clr` coincides with a counted transfer, the counter becomes 0; the clear wins.
- Each stage holds a valid bit. A stage loads when it is empty or its contents move forward the same cycle.

## Timing
- Latency: 2 cycles from input transfer to `out_valid`, with no stalls.
- Throughput: 1 operand per cycle while `out_ready` is held high.
- `in_ready = !s1_valid || !s2_valid || out_ready`. This is a combinational path from `out_ready` and is permitted.
- Outputs are registered. While `out_valid && !out_ready`, all `out_*` signals hold stable.
- The producer must hold the input fields stable while `in_valid && !in_ready`.
- Reset:
  - Both stage valid bits clear, `out_valid`=0, `in_ready`=1 in the first cycle after reset.
  - All `out_*` data signals are 0 and both counters are 0.
- Reset asserted mid-stream discards both in-flight operands; nothing is emitted.
- Back-pressure: with `out_ready`=0 the stage absorbs exactly 2 operands, then `in_ready` drops.
- Simultaneous output transfer and input transfer with both stages full: all operands shift, none is lost or duplicated.

## Structure
- Shared posit package holds:
  - Parameter defaults N, ES, RS, FS, SW.
  - A 2-bit class enum: NORMAL, ZERO, NAR.
  - A packed unpacked-operand struct {sign, scale, sig, class}, reused by the downstream multiplier and adder.
- Sub-module `posit_sat_counter` (CW, inc, clr), instantiated twice.
- The rest stays flat.

## Test plan
- Operand 0x40: fields sign0, r=0, e=0, frac=0 -> after 2 cycles scale=0, sig=5'b10000, zero=0, nar=0.
- Operand 0x7F: r=6, allone=1, e=0 -> scale=12, sig=10000. Operand 0x01: r=-6 (4'b1010) -> scale=-12.
- Operand 0xC0: sign1, r=0 -> sign=1, scale=0. Operand 0x80: inf=1 (z=1 also) -> nar=1, sign=0, sig=0, nar_cnt increments.
- Stream 5 operands with `out_ready` low for 4 cycles -> `in_ready` drops after 2 accepted; all 5 emerge in order with no loss.
- Send 300 zero operands -> zero_cnt saturates at 255. Pulse `cnt_clr` on the same cycle as a zero transfer -> zero_cnt reads 0.
- Assert `rst` with both stages full -> next cycle `out_valid`=0, `in_ready`=1, counters 0, no stale output appears afterwards.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit definitions: default widths, operand class and the unpacked
// operand record consumed by the posit arithmetic datapath.
package posit_pkg;

   localparam int N  = 8;            // posit width, matches the field decoder
   localparam int ES = 1;            // exponent field width
   localparam int RS = 4;            // regime field width (two's-complement k)
   localparam int FS = N - ES - 3;   // fraction field width
   localparam int SW = RS + ES;      // signed scale width

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ZERO   = 2'd1,
      NAR    = 2'd2
   } posit_class_e;

   // Unpacked operand as seen by the multiplier and adder.
   typedef struct packed {
      logic                 sign;
      logic signed [SW-1:0] scale;
      logic [FS:0]          sig;
      posit_class_e         cls;
   } posit_unpacked_t;

   // NaR dominates zero when the decoder raises both flags.
   function automatic posit_class_e classify(input logic is_nar, input logic is_zero);
      if (is_nar) begin
         return NAR;
      end else if (is_zero) begin
         return ZERO;
      end
      return NORMAL;
   endfunction

endpackage

// File: rtl/posit_sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module posit_sat_counter #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count
);

   // Count events, stick at all-ones, clear to zero on reset or clr.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CW{1'b1}})) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/posit_unpack_stage.sv
// Two-stage valid/ready pipeline that turns decoded posit fields into a
// class, a unified signed scale k*2^ES + e and a significand with hidden bit.
module posit_unpack_stage #(
   parameter int N  = posit_pkg::N,
   parameter int ES = posit_pkg::ES,
   parameter int RS = posit_pkg::RS,
   parameter int FS = N - ES - 3,
   parameter int SW = RS + ES,
   parameter int CW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [RS-1:0]        in_r,
   input  logic [ES-1:0]        in_e,
   input  logic [FS-1:0]        in_frac,
   input  logic                 in_z,
   input  logic                 in_inf,
   input  logic                 in_allone,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic signed [SW-1:0] out_scale,
   output logic [FS:0]          out_sig,
   output logic                 out_zero,
   output logic                 out_nar,
   input  logic                 cnt_clr,
   output logic [CW-1:0]        zero_cnt,
   output logic [CW-1:0]        nar_cnt
);

   // The regime already encodes maxpos correctly, so the flag carries no work here.
   logic unused_allone;
   assign unused_allone = in_allone;

   // ---------------------------------------------------------------- control
   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_load;
   logic in_fire;

   posit_pkg::posit_class_e in_cls;

   // A stage may load when it is empty or its contents leave this cycle.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;
   assign in_fire  = in_valid && s1_load;
   assign in_cls   = posit_pkg::classify(in_inf, in_z);

   // ---------------------------------------------------------------- stage 1
   logic                    s1_sign;
   logic [RS-1:0]           s1_r;
   logic [ES-1:0]           s1_e;
   logic [FS-1:0]           s1_frac;
   posit_pkg::posit_class_e s1_cls;

   // Stage 1: capture the raw fields and the resolved class.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, regardless of the order the blocks are evaluated in.
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_r     <= '0;
         s1_e     <= '0;
         s1_frac  <= '0;
         s1_cls   <= posit_pkg::NORMAL;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= in_sign;
            s1_r    <= in_r;
            s1_e    <= in_e;
            s1_frac <= in_frac;
            s1_cls  <= in_cls;
         end
      end
   end

   // ------------------------------------------------------- stage 2 datapath
   logic signed [SW-1:0] k_ext;
   logic [SW-1:0]        scale_d;
   logic [FS:0]          sig_d;
   logic                 sign_d;

   // Scale = sign-extended k shifted by ES plus the unsigned exponent; zero
   // and NaR leave a clean all-zero payload behind.
   always_comb begin
      // NOTE: every output of this block is assigned up front so no path can
      // leave one unassigned and infer a latch.
      k_ext   = {{ES{s1_r[RS-1]}}, s1_r};
      scale_d = (k_ext <<< ES) + {{RS{1'b0}}, s1_e};
      sig_d   = {1'b1, s1_frac};
      sign_d  = s1_sign;
      if (s1_cls != posit_pkg::NORMAL) begin
         scale_d = '0;
         sig_d   = '0;
         sign_d  = 1'b0;
      end
   end

   // ---------------------------------------------------------------- stage 2
   posit_pkg::posit_class_e s2_cls;

   // Stage 2: registered outputs, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         out_sign  <= 1'b0;
         out_scale <= '0;
         out_sig   <= '0;
         s2_cls    <= posit_pkg::NORMAL;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_sign  <= sign_d;
            out_scale <= scale_d;
            out_sig   <= sig_d;
            s2_cls    <= s1_cls;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_zero  = (s2_cls == posit_pkg::ZERO);
   assign out_nar   = (s2_cls == posit_pkg::NAR);

   // --------------------------------------------------------------- counters
   posit_sat_counter #(.CW(CW)) u_zero_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_fire && (in_cls == posit_pkg::ZERO)),
      .clr   (cnt_clr),
      .count (zero_cnt)
   );

   posit_sat_counter #(.CW(CW)) u_nar_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_fire && (in_cls == posit_pkg::NAR)),
      .clr   (cnt_clr),
      .count (nar_cnt)
   );

endmodule

// File: tb/tb_posit_unpack_stage.sv
// Randomised scoreboard bench for posit_unpack_stage: a monitor compares every
// output transfer against values computed from the posit rules with integers.
module tb_posit_unpack_stage;
   import posit_pkg::*;

   localparam int CW     = 8;
   localparam int CW_MAX = (1 << CW) - 1;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sign;
   logic [RS-1:0]        in_r;
   logic [ES-1:0]        in_e;
   logic [FS-1:0]        in_frac;
   logic                 in_z;
   logic                 in_inf;
   logic                 in_allone;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sign;
   logic signed [SW-1:0] out_scale;
   logic [FS:0]          out_sig;
   logic                 out_zero;
   logic                 out_nar;
   logic                 cnt_clr;
   logic [CW-1:0]        zero_cnt;
   logic [CW-1:0]        nar_cnt;

   posit_unpack_stage #(.CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_r      (in_r),
      .in_e      (in_e),
      .in_frac   (in_frac),
      .in_z      (in_z),
      .in_inf    (in_inf),
      .in_allone (in_allone),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_scale (out_scale),
      .out_sig   (out_sig),
      .out_zero  (out_zero),
      .out_nar   (out_nar),
      .cnt_clr   (cnt_clr),
      .zero_cnt  (zero_cnt),
      .nar_cnt   (nar_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit sign;
      int scale;
      int sig;
      bit zero;
      bit nar;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   accepted = 0;
   int   m_zero   = 0;
   int   m_nar    = 0;
   bit   done     = 0;
   bit   have_hold = 0;
   logic [SW+FS+4:0] hold_snap;

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference: value = (-1)^s * 2^(k*2^ES + e) * (1 + frac/2^FS).
   function automatic exp_t ref_model(input bit s, input int k, input int e,
                                      input int f, input bit z, input bit inf);
      exp_t r;
      r.sign = 0; r.scale = 0; r.sig = 0; r.zero = 0; r.nar = 0;
      if (inf) begin
         r.nar = 1;
      end else if (z) begin
         r.zero = 1;
      end else begin
         r.sign  = s;
         r.scale = k * (2 ** ES) + e;
         r.sig   = (2 ** FS) + f;
      end
      return r;
   endfunction

   // Monitor: scoreboard pop, stall stability, counter model, input capture.
   always @(negedge clk) begin
      exp_t x;
      if (rst) begin
         sb.delete();
         m_zero    = 0;
         m_nar     = 0;
         have_hold = 0;
      end else begin
         check("zero_cnt", zero_cnt, m_zero);
         check("nar_cnt", nar_cnt, m_nar);
         if (have_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {out_sign, out_scale, out_sig, out_zero, out_nar}, hold_snap);
         end
         have_hold = 0;
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("out_without_expect", out_valid, 0);
            end else if (out_ready) begin
               x = sb.pop_front();
               check("out_sign", out_sign, x.sign);
               check("out_scale", out_scale, x.scale);
               check("out_sig", out_sig, x.sig);
               check("out_zero", out_zero, x.zero);
               check("out_nar", out_nar, x.nar);
            end
            if (!out_ready) begin
               have_hold = 1;
               hold_snap = {out_sign, out_scale, out_sig, out_zero, out_nar};
            end
         end
         if (in_valid && in_ready) begin
            x = ref_model(in_sign, int'($signed(in_r)), int'(in_e), int'(in_frac), in_z, in_inf);
            sb.push_back(x);
            accepted++;
            if (x.nar && m_nar < CW_MAX) m_nar++;
            if (x.zero && m_zero < CW_MAX) m_zero++;
         end
         if (cnt_clr) begin
            m_zero = 0;
            m_nar  = 0;
         end
      end
   end

   // Present one operand from posedge+1 and hold it until it is accepted.
   task automatic send(input bit s, input int k, input int e, input int f,
                       input bit z, input bit inf, input bit allone);
      int n = 0;
      in_sign   = s;
      in_r      = k[RS-1:0];
      in_e      = e[ES-1:0];
      in_frac   = f[FS-1:0];
      in_z      = z;
      in_inf    = inf;
      in_allone = allone;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("in_ready_timeout", n, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      int sel = $urandom_range(0, 9);
      send(1'($urandom_range(0, 1)), $urandom_range(0, 15) - 8, $urandom_range(0, 1),
           $urandom_range(0, 15), (sel == 0 || sel == 2), (sel == 1 || sel == 2), 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_r = '0; in_e = '0;
      in_frac = '0; in_z = 1'b0; in_inf = 1'b0; in_allone = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b0;

      // Reset state
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", {out_sign, out_scale, out_sig, out_zero, out_nar}, 0);
      check("rst_zero_cnt", zero_cnt, 0);
      check("rst_nar_cnt", nar_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // 0x40: two-cycle latency and the unit value
      send(0, 0, 0, 0, 0, 0, 0);
      check("lat_not_early", out_valid, 0);
      @(posedge clk); #1;
      check("lat_valid", out_valid, 1);
      check("x40_scale", out_scale, 0);
      check("x40_sig", out_sig, 16);
      check("x40_class", {out_zero, out_nar}, 0);
      drain();

      // 0x7F, 0x01, 0xC0, 0x80 back to back
      send(0, 6, 0, 0, 0, 0, 1);
      send(0, -6, 0, 0, 0, 0, 0);
      send(1, 0, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 1, 1, 0);
      drain();
      check("nar_cnt_after_x80", nar_cnt, 1);
      check("zero_cnt_after_x80", zero_cnt, 0);

      // Back-pressure: exactly two operands absorbed while out_ready is low
      out_ready = 1'b0;
      base = accepted;
      fork
         begin
            for (int i = 0; i < 5; i++) send(0, i - 2, i % 2, i * 3, 0, 0, 0);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            check("bp_accepted", accepted - base, 2);
            check("bp_in_ready", in_ready, 0);
            out_ready = 1'b1;
         end
      join
      drain();

      // Random stream with random consumer stalls
      done = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) send_rand();
            done = 1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Saturation and clear priority
      for (int i = 0; i < 300; i++) send(0, 0, 0, 0, 1, 0, 0);
      drain();
      check("zero_cnt_sat", zero_cnt, CW_MAX);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      check("zero_cnt_clr", zero_cnt, 0);
      for (int i = 0; i < 3; i++) send(0, 0, 0, 0, 1, 0, 0);
      check("zero_cnt_three", zero_cnt, 3);
      cnt_clr = 1'b1;
      send(0, 0, 0, 0, 1, 0, 0);
      cnt_clr = 1'b0;
      check("zero_cnt_clr_wins", zero_cnt, 0);
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      send(0, 0, 0, 0, 0, 1, 0);
      send(0, 0, 0, 0, 0, 1, 0);
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_nar_cnt", nar_cnt, 0);
      check("mid_rst_out_data", {out_sign, out_scale, out_sig, out_zero, out_nar}, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale_out", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
